// File: rtl/qupls_io_order.sv
// qupls_io_order: classifies decoded memory ops as I/O (cache attribute ==
// IO_CA), queues their ROB tags in program order and releases them to the
// memory pipeline one at a time, waiting for completion before the next.
// Optional watchdog: define QUPLS_IO_TIMEOUT_EN to force-pop an ISSUED head
// after TIMEOUT cycles without completion.
module qupls_io_order #(
  parameter int NLANE   = 4,
  parameter int DEPTH   = 8,
  parameter int TAGW    = 6,
  parameter int CAW     = 3,
  parameter int IO_CA   = 0,
  parameter int TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [NLANE-1:0]             lane_valid_i,
  input  logic [NLANE-1:0]             lane_mem_i,
  input  logic [NLANE*CAW-1:0]         lane_ca_i,
  input  logic [NLANE*TAGW-1:0]        lane_tag_i,
  output logic [NLANE-1:0]             lane_io_o,
  output logic                         alloc_ready_o,
  output logic                         issue_valid_o,
  output logic [TAGW-1:0]              issue_tag_o,
  input  logic                         issue_ack_i,
  input  logic                         done_i,
  input  logic [TAGW-1:0]              done_tag_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         busy_o,
  output logic                         err_o,
  output logic                         timeout_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(NLANE+1);

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_ISSUED} hstate_e;

  hstate_e           state_q, state_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic [TAGW-1:0]   tags_q [DEPTH];

  logic [NLANE-1:0]  io;
  logic [NW-1:0]     nio;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     slot [NLANE];
  logic              alloc_ready, do_alloc, pop, ack_ok, keep, timeout_hit;

  // Classify lanes and assign consecutive tail slots to I/O lanes in lane order
  always_comb begin
    io  = '0;
    nio = '0;
    ptr = tail_q;
    for (int unsigned l = 0; l < NLANE; l++) begin
      io[l]   = lane_valid_i[l] & lane_mem_i[l] &
                (lane_ca_i[l*CAW +: CAW] == CAW'(IO_CA));
      slot[l] = ptr;
      if (io[l]) begin
        ptr = ptr + 1'b1;
        nio = nio + 1'b1;
      end
    end
  end

`ifdef QUPLS_IO_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT+1);
  logic [WW-1:0] wd_q, wd_d;

  // Watchdog: held at zero outside ISSUED, counts cycles spent in ISSUED
  always_comb wd_d = (state_q == ST_ISSUED) ? wd_q + 1'b1 : '0;

  // Watchdog register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end

  assign timeout_hit = (state_q == ST_ISSUED) && (wd_q == WW'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  // Head state machine, pointer and occupancy next-state
  always_comb begin
    pop         = (state_q == ST_ISSUED) &&
                  ((done_i && (tags_q[head_q] == done_tag_i)) || timeout_hit);
    ack_ok      = (state_q == ST_WAIT) && issue_ack_i;
    alloc_ready = (32'(DEPTH) - 32'(count_q)) >= 32'(nio);
    do_alloc    = alloc_ready && !flush_i && (nio != '0);
    err_d       = err_q | (issue_ack_i && (state_q != ST_WAIT)) | timeout_hit;
    keep        = 1'b0;
    head_d      = head_q + PW'(pop);
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    if (flush_i) begin
      // Only a head already handed to memory (or handed over this cycle)
      // survives; it cannot be cancelled.
      keep    = ((state_q == ST_ISSUED) && !pop) || ack_ok;
      tail_d  = head_d + PW'(keep);
      count_d = CW'(keep);
      state_d = keep ? ST_ISSUED : ST_EMPTY;
    end else begin
      if (do_alloc) tail_d = tail_q + PW'(nio);
      count_d = count_q + (do_alloc ? CW'(nio) : '0) - CW'(pop);
      if (pop)                        state_d = (count_d != '0) ? ST_WAIT : ST_EMPTY;
      else if (ack_ok)                state_d = ST_ISSUED;
      else if (state_q == ST_EMPTY)   state_d = (count_d != '0) ? ST_WAIT : ST_EMPTY;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Tag storage; contents are only observed while the entry is occupied
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      for (int unsigned l = 0; l < NLANE; l++) begin
        if (io[l]) tags_q[slot[l]] <= lane_tag_i[l*TAGW +: TAGW];
      end
    end
  end

  assign lane_io_o     = io;
  assign alloc_ready_o = alloc_ready;
  assign issue_valid_o = (state_q == ST_WAIT);
  assign issue_tag_o   = (count_q != '0) ? tags_q[head_q] : '0;
  assign count_o       = count_q;
  assign busy_o        = (count_q != '0);
  assign err_o         = err_q;
  assign timeout_o     = timeout_hit;

endmodule
